dequant_scale_bank: RTL and testbench
=====================================

// Module: dequant_scale_bank
// PURPOSE
//  Parametrised successor of the dequant-scale store: bus-loaded bank array of
//  dequantisation scales with an explicit load sequence, two bank-mapping modes
//  and a registered, BRAM-friendly random-access read port with status flags.
//  Sits between the weight-load bus and the dequant datapath of each conv stage.
// PARAMETERS
//  pDATA_WIDTH   64             width of one scale word
//  pBASE_ADDR    32'h4000_0000  first word address of this block's window
//  pDEPTH        32             entries per bank (power of 2, >=2)
//  pBANK_NUM     32             number of banks (>=2)
//  pADDR_MODE    0              0=AUTO (round-robin bank), 1=DIRECT (bank from addr)
// PORTS
//  clk          in   1                       clock
//  rst_n        in   1                       synchronous reset, active low
//  load_start   in   1                       pulse: begin/restart a load sequence
//  wr_en        in   1                       bus write strobe
//  weight_addr  in   32                      bus word address
//  weight_data  in   pDATA_WIDTH             bus write data
//  rd_en        in   1                       read request
//  rd_bank      in   $clog2(pBANK_NUM)       read bank index
//  rd_addr      in   $clog2(pDEPTH)          read entry index
//  rd_data      out  pDATA_WIDTH             read data (registered)
//  rd_valid     out  1                       rd_data valid, 1-cycle pulse
//  rd_err       out  1                       1-cycle pulse: read refused
//  busy         out  1                       state==LOAD
//  load_done    out  1                       state==DONE
//  wr_cnt       out  $clog2(pBANK_NUM*pDEPTH+1)  accepted writes this load
//  wr_err       out  1                       sticky: in-window write outside LOAD
// BEHAVIOUR
//  - Reset (rst_n=0 at clk edge): state=IDLE, bank ptr=0, wr_cnt=0, rd_valid=0,
//    rd_err=0, wr_err=0, rd_data=0. Memory contents are NOT cleared.
//  - cs: AUTO: off=weight_addr-pBASE_ADDR, cs = addr in [base, base+pDEPTH).
//        DIRECT: cs = addr in [base, base+pBANK_NUM*pDEPTH); bank=off/pDEPTH,
//        entry=off%pDEPTH. Out-of-window writes ignored silently, no flags.
//  - FSM IDLE/LOAD/DONE. Any state + load_start -> LOAD: wr_cnt=0, ptr=0,
//    wr_err cleared. load_start wins over a same-cycle write (write dropped).
//  - LOAD: write accepted when wr_en&&cs; AUTO writes bank=ptr, entry=off,
//    ptr++ with wrap pBANK_NUM-1 -> 0; DIRECT ignores ptr. wr_cnt++ per accept.
//    Accept making wr_cnt==pBANK_NUM*pDEPTH -> DONE next cycle; that write lands.
//  - IDLE/DONE: wr_en&&cs not written; sets wr_err (holds until load_start/reset).
//  - Read: rd_en in DONE -> rd_data=mem[rd_bank][rd_addr], rd_valid=1 next
//    cycle (latency 1). rd_en in IDLE/LOAD -> rd_err=1 next cycle, rd_valid=0,
//    rd_data holds. Back-to-back reads every cycle supported.
//  - Overwrites of same entry within one load allowed; last write wins, still
//    counted. Reset or load_start mid-load abandons progress.
// TESTING (pBANK_NUM=4, pDEPTH=8 unless noted)
//  - AUTO: load_start, 32 writes addr=base+(i/4), data=i -> load_done after 32nd;
//    read bank1 addr2 -> rd_data=9, rd_valid 1 cycle after rd_en.
//  - DIRECT: 32 writes addr=base+i, data=100+i -> read bank3 addr7 = 131;
//    write to base+32 ignored, wr_cnt unchanged, wr_err stays 0.
//  - Read during LOAD at wr_cnt=5 -> rd_err pulse, rd_valid=0; write in DONE ->
//    wr_err=1 sticky, mem unchanged; next load_start clears wr_err.
//  - load_start same cycle as write at wr_cnt=10 -> wr_cnt=0, ptr=0, data dropped.
//  - rst_n low at wr_cnt=17 -> IDLE, busy=0, load_done=0, wr_cnt=0 next cycle.
//  - AUTO wrap: 5 writes same addr -> banks 0,1,2,3,0; bank0 holds 5th value.

Source files
------------

// File: rtl/dequant_scale_bank.sv
// Bus-loaded bank array of dequantisation scales with an IDLE/LOAD/DONE load
// sequence, AUTO or DIRECT bank mapping and a registered 1-cycle read port.
module dequant_scale_bank #(
    parameter int          pDATA_WIDTH = 64,
    parameter logic [31:0] pBASE_ADDR  = 32'h4000_0000,
    parameter int          pDEPTH      = 32,
    parameter int          pBANK_NUM   = 32,
    parameter int          pADDR_MODE  = 0
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   load_start,
    input  logic                                   wr_en,
    input  logic [31:0]                            weight_addr,
    input  logic [pDATA_WIDTH-1:0]                 weight_data,
    input  logic                                   rd_en,
    input  logic [$clog2(pBANK_NUM)-1:0]           rd_bank,
    input  logic [$clog2(pDEPTH)-1:0]              rd_addr,
    output logic [pDATA_WIDTH-1:0]                 rd_data,
    output logic                                   rd_valid,
    output logic                                   rd_err,
    output logic                                   busy,
    output logic                                   load_done,
    output logic [$clog2(pBANK_NUM*pDEPTH+1)-1:0]  wr_cnt,
    output logic                                   wr_err
);
    localparam int          BW    = $clog2(pBANK_NUM);
    localparam int          AW    = $clog2(pDEPTH);
    localparam int          CW    = $clog2(pBANK_NUM*pDEPTH+1);
    localparam int          IW    = BW + AW;
    localparam int          TOTAL = pBANK_NUM * pDEPTH;
    localparam logic [31:0] WIN   = (pADDR_MODE == 0) ? 32'(pDEPTH) : 32'(TOTAL);

    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

    state_t                 state;
    logic [BW-1:0]          ptr;
    logic [CW-1:0]          cnt;
    logic                   err_sticky;
    logic [pDATA_WIDTH-1:0] mem [0:TOTAL-1];

    logic [31:0]   off;
    logic          cs;
    logic [BW-1:0] w_bank;
    logic [AW-1:0] w_entry;
    logic [IW-1:0] w_idx;
    logic          wr_acc;

    // Unsigned offset: addresses below the base wrap to huge values and miss the window.
    assign off     = weight_addr - pBASE_ADDR;
    assign cs      = (off < WIN);
    assign w_entry = off[AW-1:0];
    assign w_bank  = (pADDR_MODE == 0) ? ptr : off[AW +: BW];
    assign w_idx   = {w_bank, w_entry};
    assign wr_acc  = rst_n && !load_start && (state == LOAD) && wr_en && cs;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            ptr        <= '0;
            cnt        <= '0;
            err_sticky <= 1'b0;
        end else if (load_start) begin
            state      <= LOAD;
            ptr        <= '0;
            cnt        <= '0;
            err_sticky <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    if (wr_en && cs) begin
                        cnt <= cnt + CW'(1);
                        if (pADDR_MODE == 0)
                            ptr <= (ptr == BW'(pBANK_NUM - 1)) ? '0 : ptr + BW'(1);
                        if (cnt == CW'(TOTAL - 1))
                            state <= DONE;
                    end
                end
                default: begin
                    if (wr_en && cs)
                        err_sticky <= 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc)
            mem[w_idx] <= weight_data;
    end

    // Read stage p1: registered data, valid and refusal flag.
    logic [pDATA_WIDTH-1:0] rd_data_p1;
    logic                   vld_p1;
    logic                   rd_err_p1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_data_p1 <= '0;
            vld_p1     <= 1'b0;
            rd_err_p1  <= 1'b0;
        end else begin
            vld_p1    <= rd_en && (state == DONE);
            rd_err_p1 <= rd_en && (state != DONE);
            if (rd_en && (state == DONE))
                rd_data_p1 <= mem[{rd_bank, rd_addr}];
        end
    end

    assign rd_data   = rd_data_p1;
    assign rd_valid  = vld_p1;
    assign rd_err    = rd_err_p1;
    assign busy      = (state == LOAD);
    assign load_done = (state == DONE);
    assign wr_cnt    = cnt;
    assign wr_err    = err_sticky;

endmodule

// File: tb/tb_dequant_scale_bank.sv
// Directed bench for dequant_scale_bank: one AUTO and one DIRECT instance share stimulus.
module tb_dequant_scale_bank;
    localparam logic [31:0] BASE = 32'h4000_0000;

    logic        clk;
    logic        rst_n;
    logic        load_start;
    logic        wr_en;
    logic [31:0] weight_addr;
    logic [63:0] weight_data;
    logic        rd_en;
    logic [1:0]  rd_bank;
    logic [2:0]  rd_addr;

    logic [63:0] a_rd_data, d_rd_data;
    logic        a_rd_valid, d_rd_valid, a_rd_err, d_rd_err;
    logic        a_busy, d_busy, a_load_done, d_load_done, a_wr_err, d_wr_err;
    logic [5:0]  a_wr_cnt, d_wr_cnt;

    int n_vec = 0;
    int n_err = 0;

    dequant_scale_bank #(.pDATA_WIDTH(64), .pBASE_ADDR(BASE), .pDEPTH(8),
                         .pBANK_NUM(4), .pADDR_MODE(0)) u_auto (
        .clk(clk), .rst_n(rst_n), .load_start(load_start), .wr_en(wr_en),
        .weight_addr(weight_addr), .weight_data(weight_data), .rd_en(rd_en),
        .rd_bank(rd_bank), .rd_addr(rd_addr), .rd_data(a_rd_data),
        .rd_valid(a_rd_valid), .rd_err(a_rd_err), .busy(a_busy),
        .load_done(a_load_done), .wr_cnt(a_wr_cnt), .wr_err(a_wr_err));

    dequant_scale_bank #(.pDATA_WIDTH(64), .pBASE_ADDR(BASE), .pDEPTH(8),
                         .pBANK_NUM(4), .pADDR_MODE(1)) u_dir (
        .clk(clk), .rst_n(rst_n), .load_start(load_start), .wr_en(wr_en),
        .weight_addr(weight_addr), .weight_data(weight_data), .rd_en(rd_en),
        .rd_bank(rd_bank), .rd_addr(rd_addr), .rd_data(d_rd_data),
        .rd_valid(d_rd_valid), .rd_err(d_rd_err), .busy(d_busy),
        .load_done(d_load_done), .wr_cnt(d_wr_cnt), .wr_err(d_wr_err));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  bank;
        logic [2:0]  addr;
        logic [63:0] exp;
    } rd_vec_t;

    rd_vec_t auto_tab [6];
    rd_vec_t dir_tab  [6];
    logic [63:0] last_d;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wr(input logic [31:0] addr, input logic [63:0] data);
        wr_en       = 1'b1;
        weight_addr = addr;
        weight_data = data;
        tick();
        wr_en       = 1'b0;
    endtask

    task automatic pulse_load();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
    endtask

    task automatic rd1(input logic [1:0] b, input logic [2:0] a);
        rd_en   = 1'b1;
        rd_bank = b;
        rd_addr = a;
        tick();
        rd_en   = 1'b0;
    endtask

    initial begin
        // Expected contents: AUTO load gives mem[b][e]=4e+b, DIRECT load gives 100+8b+e.
        auto_tab[0] = '{2'd1, 3'd2, 64'd9};
        auto_tab[1] = '{2'd3, 3'd7, 64'd31};
        auto_tab[2] = '{2'd0, 3'd0, 64'd0};
        auto_tab[3] = '{2'd2, 3'd4, 64'd18};
        auto_tab[4] = '{2'd0, 3'd5, 64'd20};
        auto_tab[5] = '{2'd3, 3'd1, 64'd7};
        dir_tab[0]  = '{2'd3, 3'd7, 64'd131};
        dir_tab[1]  = '{2'd0, 3'd0, 64'd100};
        dir_tab[2]  = '{2'd1, 3'd2, 64'd110};
        dir_tab[3]  = '{2'd2, 3'd5, 64'd121};
        dir_tab[4]  = '{2'd0, 3'd7, 64'd107};
        dir_tab[5]  = '{2'd3, 3'd0, 64'd124};

        rst_n = 1'b0; load_start = 1'b0; wr_en = 1'b0; weight_addr = '0;
        weight_data = '0; rd_en = 1'b0; rd_bank = '0; rd_addr = '0;
        tick(); tick();
        chk("reset busy", a_busy, 0);
        chk("reset load_done", a_load_done, 0);
        chk("reset wr_cnt", a_wr_cnt, 0);
        chk("reset rd_valid", a_rd_valid, 0);
        chk("reset rd_err", d_rd_err, 0);
        chk("reset wr_err", d_wr_err, 0);
        chk("reset rd_data", a_rd_data, 0);
        rst_n = 1'b1;
        tick();

        // AUTO load: round-robin banks, entry from address.
        pulse_load();
        chk("auto busy after start", a_busy, 1);
        for (int i = 0; i < 32; i++) begin
            wr(BASE + 32'(i / 4), 64'(i));
            if (i == 30) begin
                chk("auto not done at 31", a_load_done, 0);
                chk("auto wr_cnt 31", a_wr_cnt, 31);
            end
        end
        chk("auto load_done", a_load_done, 1);
        chk("auto busy end", a_busy, 0);
        chk("auto wr_cnt 32", a_wr_cnt, 32);
        rd_en = 1'b1;
        for (int k = 0; k < 6; k++) begin
            rd_bank = auto_tab[k].bank;
            rd_addr = auto_tab[k].addr;
            tick();
            chk($sformatf("auto rd_valid %0d", k), a_rd_valid, 1);
            chk($sformatf("auto rd b%0d a%0d", auto_tab[k].bank, auto_tab[k].addr),
                a_rd_data, auto_tab[k].exp);
        end
        rd_en = 1'b0;
        tick();
        chk("auto rd_valid pulse ends", a_rd_valid, 0);

        // DIRECT load: bank and entry from address.
        pulse_load();
        for (int i = 0; i < 32; i++) wr(BASE + 32'(i), 64'(100 + i));
        chk("dir load_done", d_load_done, 1);
        rd_en = 1'b1;
        for (int k = 0; k < 6; k++) begin
            rd_bank = dir_tab[k].bank;
            rd_addr = dir_tab[k].addr;
            tick();
            chk($sformatf("dir rd_valid %0d", k), d_rd_valid, 1);
            chk($sformatf("dir rd b%0d a%0d", dir_tab[k].bank, dir_tab[k].addr),
                d_rd_data, dir_tab[k].exp);
        end
        rd_en = 1'b0;
        last_d = dir_tab[5].exp;
        wr(BASE + 32'd32, 64'd555);
        chk("dir out-of-window wr_cnt", d_wr_cnt, 32);
        chk("dir out-of-window wr_err", d_wr_err, 0);

        // Read refused during LOAD; write in DONE sets sticky wr_err.
        pulse_load();
        for (int i = 0; i < 5; i++) wr(BASE + 32'(i), 64'(200 + i));
        chk("err wr_cnt 5", d_wr_cnt, 5);
        rd1(2'd3, 3'd7);
        chk("load read rd_err", d_rd_err, 1);
        chk("load read rd_valid", d_rd_valid, 0);
        chk("load read rd_data holds", d_rd_data, last_d);
        tick();
        chk("rd_err pulse ends", d_rd_err, 0);
        for (int i = 5; i < 32; i++) wr(BASE + 32'(i), 64'(200 + i));
        chk("err load_done", d_load_done, 1);
        wr(BASE, 64'd999);
        chk("done write wr_err", d_wr_err, 1);
        tick();
        chk("wr_err sticky", d_wr_err, 1);
        rd1(2'd0, 3'd0);
        chk("done write mem unchanged", d_rd_data, 200);

        // load_start colliding with a write; then AUTO pointer wrap.
        pulse_load();
        chk("load_start clears wr_err", d_wr_err, 0);
        for (int i = 0; i < 10; i++) wr(BASE + 32'(i % 8), 64'(300 + i));
        chk("coll a wr_cnt 10", a_wr_cnt, 10);
        chk("coll d wr_cnt 10", d_wr_cnt, 10);
        load_start = 1'b1;
        wr(BASE + 32'd2, 64'd777);
        load_start = 1'b0;
        chk("coll a wr_cnt 0", a_wr_cnt, 0);
        chk("coll d wr_cnt 0", d_wr_cnt, 0);
        chk("coll busy", d_busy, 1);
        for (int i = 0; i < 5; i++) wr(BASE, 64'(500 + i));
        chk("wrap a wr_cnt 5", a_wr_cnt, 5);
        for (int j = 0; j < 27; j++) wr(BASE + 32'd1, 64'(600 + j));
        chk("wrap a load_done", a_load_done, 1);
        chk("wrap d load_done", d_load_done, 1);
        rd1(2'd0, 3'd0);
        chk("wrap bank0 5th value", a_rd_data, 504);
        chk("dir bank0 a0 last write", d_rd_data, 504);
        rd1(2'd1, 3'd0);
        chk("wrap bank1", a_rd_data, 501);
        rd1(2'd3, 3'd0);
        chk("wrap bank3", a_rd_data, 503);
        rd1(2'd0, 3'd2);
        chk("coll write dropped", d_rd_data, 302);

        // Reset mid-load abandons progress.
        pulse_load();
        for (int i = 0; i < 17; i++) wr(BASE + 32'(i), 64'(900 + i));
        chk("mid wr_cnt 17", d_wr_cnt, 17);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mid reset busy", d_busy, 0);
        chk("mid reset load_done", d_load_done, 0);
        chk("mid reset wr_cnt", d_wr_cnt, 0);
        chk("mid reset a wr_cnt", a_wr_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
